// File: rtl/conv3_bram_pkg.sv
// Shared constants and FSM state type for the Conv2D_3 BRAM stream reader.
package conv3_bram_pkg;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] BRAM_WE_NONE   = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/bram_rd_fifo.sv
// Synchronous output buffer for returned BRAM words; each entry carries data plus its end-of-run flag.
module bram_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv3_bram_stream_reader.sv
// Port-A read initiator: streams a run of 32-bit words from the Conv2D_3 BRAM as valid/ready beats.
// Stream handshake: a beat transfers on a cycle with m_valid && m_ready; once m_valid is high it stays
// high with m_data/m_last unchanged until that transfer.
module conv3_bram_stream_reader
  import conv3_bram_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             BRAM_PORTA_0_clk,
  output logic [31:0]      BRAM_PORTA_0_addr,
  output logic [31:0]      BRAM_PORTA_0_din,
  input  logic [31:0]      BRAM_PORTA_0_dout,
  output logic             BRAM_PORTA_0_en,
  output logic [3:0]       BRAM_PORTA_0_we,
  output state_t           dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q;
  state_t            state_d;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       base_q;
  logic [LEN_W-1:0]  num_q;
  logic [LEN_W-1:0]  issued_q;
  logic [CW-1:0]     inflight_q;
  logic [CW-1:0]     fifo_count;
  logic [RD_LAT-1:0] pipe_v_q;
  logic [RD_LAT-1:0] pipe_l_q;

  logic              accept;
  logic              issue;
  logic              issue_last;
  logic              credit;
  logic              land;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [32:0]       fifo_head;

  // busy_q stays high through the done cycle, which also blocks a start coinciding with done.
  assign accept     = (state_q == IDLE) && start && !busy_q;
  assign issue_last = (issued_q == (num_q - LEN_W'(1)));
  // Registered counts only: a pop this cycle frees credit from the next cycle on.
  assign credit     = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign land       = pipe_v_q[RD_LAT-1];
  assign pop        = !fifo_empty && m_ready;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (num_words == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (credit) begin
          issue = 1'b1;
          if (issue_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_head[32]) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      inflight_q <= '0;
      pipe_v_q   <= '0;
      pipe_l_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FIN);

      if (accept) begin
        busy_q   <= 1'b1;
        base_q   <= {base_addr[31:2], 2'b00};
        num_q    <= num_words;
        issued_q <= '0;
      end else begin
        if (done_q) begin
          busy_q <= 1'b0;
        end
        if (issue) begin
          issued_q <= issued_q + LEN_W'(1);
        end
      end

      inflight_q <= inflight_q + CW'(issue) - CW'(land);

      // One slot per cycle of read latency; the last stage lines up with valid dout.
      pipe_v_q[0] <= issue;
      pipe_l_q[0] <= issue && issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_l_q[i] <= pipe_l_q[i-1];
      end
    end
  end

  bram_rd_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (land),
    .push_data ({pipe_l_q[RD_LAT-1], BRAM_PORTA_0_dout}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_head[31:0] : 32'h0;
  assign m_last  = m_valid && fifo_head[32];
  assign busy    = busy_q;
  assign done    = done_q;

  // Address arithmetic is 32-bit and wraps naturally past the top of the byte space.
  assign BRAM_PORTA_0_clk  = clk;
  assign BRAM_PORTA_0_addr = base_q + (32'(issued_q) * 32'(BYTES_PER_WORD));
  assign BRAM_PORTA_0_din  = 32'h0;
  assign BRAM_PORTA_0_en   = issue;
  assign BRAM_PORTA_0_we   = BRAM_WE_NONE;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_conv3_bram_stream_reader.sv
// Self-checking bench for conv3_bram_stream_reader (RD_LAT=1 main instance, RD_LAT=2 latency instance).
module tb_conv3_bram_stream_reader;
  import conv3_bram_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 16;
  localparam int W          = 33;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (RD_LAT=1) ----------------
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] num_words;
  logic             busy, done, m_valid, m_ready, m_last;
  logic [31:0]      m_data;
  logic             bram_clk, bram_en;
  logic [31:0]      bram_addr, bram_din, bram_dout;
  logic [3:0]       bram_we;
  state_t           dbg_state;

  conv3_bram_stream_reader #(.RD_LAT(1), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .BRAM_PORTA_0_clk(bram_clk), .BRAM_PORTA_0_addr(bram_addr), .BRAM_PORTA_0_din(bram_din),
    .BRAM_PORTA_0_dout(bram_dout), .BRAM_PORTA_0_en(bram_en), .BRAM_PORTA_0_we(bram_we),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT 2 (RD_LAT=2) ----------------
  logic             start_2;
  logic [31:0]      base_addr_2;
  logic [LEN_W-1:0] num_words_2;
  logic             busy_2, done_2, m_valid_2, m_last_2;
  logic             m_ready_2 = 1'b1;
  logic [31:0]      m_data_2;
  logic             bram_clk_2, bram_en_2;
  logic [31:0]      bram_addr_2, bram_din_2, bram_dout_2, bram_s1_2;
  logic [3:0]       bram_we_2;
  state_t           dbg_state_2;

  conv3_bram_stream_reader #(.RD_LAT(2), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) u_dut_2 (
    .clk(clk), .rst_n(rst_n), .start(start_2), .base_addr(base_addr_2), .num_words(num_words_2),
    .busy(busy_2), .done(done_2), .m_data(m_data_2), .m_valid(m_valid_2), .m_ready(m_ready_2),
    .m_last(m_last_2), .BRAM_PORTA_0_clk(bram_clk_2), .BRAM_PORTA_0_addr(bram_addr_2),
    .BRAM_PORTA_0_din(bram_din_2), .BRAM_PORTA_0_dout(bram_dout_2), .BRAM_PORTA_0_en(bram_en_2),
    .BRAM_PORTA_0_we(bram_we_2), .dbg_state(dbg_state_2)
  );

  // BRAM content: word at byte address 0x100+4i holds 0xA0+i.
  function automatic logic [31:0] bram_word(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h100) >> 2);
  endfunction

  always @(posedge clk) begin
    bram_dout   <= bram_en ? bram_word(bram_addr) : 32'hDEAD_BEEF;
    bram_s1_2   <= bram_en_2 ? bram_word(bram_addr_2) : 32'hDEAD_BEEF;
    bram_dout_2 <= bram_s1_2;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [W-1:0] exp2_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int hs_count = 0;
  int occ = 0;
  int ready_mode = 0;
  bit stalled = 1'b0;
  logic [W-1:0] stall_word;

  // Sampled on the falling edge: values here are what the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
      occ     = 0;
    end else begin
      if (bram_en) begin
        n_cmp++;
        if (occ >= FIFO_DEPTH) begin
          n_err++;
          $display("FAIL credit: en with %0d words outstanding, required < %0d", occ, FIFO_DEPTH);
        end
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_en: addr=%08h, required no read", bram_addr);
        end else begin
          logic [31:0] ea;
          ea = exp_addr_q.pop_front();
          if (bram_addr !== ea) begin
            n_err++;
            $display("FAIL read_addr: got %08h, required %08h", bram_addr, ea);
          end
        end
      end
      if (stalled) begin
        n_cmp++;
        if (m_valid !== 1'b1 || {m_last, m_data} !== stall_word) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b word=%09h, required valid=1 word=%09h",
                   m_valid, {m_last, m_data}, stall_word);
        end
      end
      if (m_valid === 1'b1) begin
        if (m_ready) begin
          n_cmp++;
          hs_count++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL spurious_beat: got %09h, required no beat", {m_last, m_data});
          end else begin
            logic [W-1:0] ew;
            ew = exp_q.pop_front();
            if ({m_last, m_data} !== ew) begin
              n_err++;
              $display("FAIL stream_beat: got last=%0b data=%08h, required last=%0b data=%08h",
                       m_last, m_data, ew[32], ew[31:0]);
            end
          end
        end
        stalled    = !m_ready;
        stall_word = {m_last, m_data};
      end else begin
        stalled = 1'b0;
      end
      occ = occ + (bram_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic push_run(input logic [31:0] base, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = {base[31:2], 2'b00} + 32'(i) * 32'd4;
      exp_addr_q.push_back(a);
      exp_q.push_back({(i == n - 1), bram_word(a)});
    end
  endtask

  // exp_lat: edges from the accepting edge to first m_valid, or -1 to skip.
  task automatic run_stream(input string name, input logic [31:0] base, input int n,
                            input int mode, input int exp_lat);
    int cyc;
    int first_v;
    ready_mode = mode;
    m_ready    = 1'b1;
    push_run(base, n);
    base_addr = base;
    num_words = LEN_W'(n);
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_after_start: got %0b, required 1", name, busy);
    end
    cyc     = 0;
    first_v = -1;
    while (done !== 1'b1 && cyc < 600) begin
      if (first_v < 0 && m_valid === 1'b1) first_v = cyc;
      tick();
      cyc++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_timeout: no done after %0d cycles, required done", name, cyc);
    end
    if (exp_lat >= 0) begin
      n_cmp++;
      if (first_v != exp_lat) begin
        n_err++;
        $display("FAIL %s first_valid_latency: got %0d, required %0d", name, first_v, exp_lat);
      end
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_in_done_cycle: got %0b, required 1", name, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_err++;
      $display("FAIL %s leftover: got %0d beats / %0d reads outstanding, required 0 / 0",
               name, exp_q.size(), exp_addr_q.size());
      exp_q.delete();
      exp_addr_q.delete();
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_done: got done=%0b busy=%0b, required 0 0", name, done, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; base_addr = '0; num_words = '0; m_ready = 1'b0;
    start_2 = 1'b0; base_addr_2 = '0; num_words_2 = '0;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %0b, required 0", done); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b, required 0", m_valid); end
    n_cmp++; if (m_last !== 1'b0)  begin n_err++; $display("FAIL reset_last: got %0b, required 0", m_last); end
    n_cmp++; if (m_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %08h, required 0", m_data); end
    n_cmp++; if (bram_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %0b, required 0", bram_en); end
    n_cmp++; if (bram_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %08h, required 0", bram_addr); end
    n_cmp++; if (bram_we !== 4'h0 || bram_din !== 32'h0) begin
      n_err++; $display("FAIL reset_we_din: got we=%h din=%08h, required 0 0", bram_we, bram_din);
    end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required IDLE", dbg_state); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_len();
    ready_mode = 0;
    base_addr = 32'h200; num_words = '0; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL zero_len_cycle1: got busy=%0b done=%0b, required 1 0", busy, done);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      n_err++; $display("FAIL zero_len_cycle2: got busy=%0b done=%0b, required 1 1", busy, done);
    end
    n_cmp++;
    if (m_valid !== 1'b0 || bram_en !== 1'b0) begin
      n_err++; $display("FAIL zero_len_quiet: got valid=%0b en=%0b, required 0 0", m_valid, bram_en);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL zero_len_end: got busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_abort();
    int hs0;
    int c;
    bit saw_done;
    ready_mode = 0;
    push_run(32'h300, 10);
    hs0 = hs_count;
    base_addr = 32'h300; num_words = LEN_W'(10); start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (hs_count - hs0 < 3 && c < 100) begin
      tick();
      c++;
    end
    n_cmp++;
    if (hs_count - hs0 < 3) begin
      n_err++; $display("FAIL abort_progress: got %0d beats, required 3", hs_count - hs0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    n_cmp++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || bram_en !== 1'b0) begin
      n_err++;
      $display("FAIL abort_clear: got busy=%0b valid=%0b en=%0b, required 0 0 0", busy, m_valid, bram_en);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_cmp++;
    if (saw_done) begin
      n_err++; $display("FAIL abort_no_done: got done/busy activity, required none");
    end
    run_stream("abort_rerun", 32'h500, 2, 0, 2);
  endtask

  task automatic test_start_ignored();
    int cyc;
    bit quiet;
    ready_mode = 0;
    push_run(32'h400, 6);
    base_addr = 32'h400; num_words = LEN_W'(6); start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == 2) begin
        start = 1'b1; base_addr = 32'h800; num_words = LEN_W'(5);
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL start_busy_run: got done=%0b leftover=%0d, required 1 0", done, exp_q.size());
    end
    // Start presented in the done cycle.
    start = 1'b1; base_addr = 32'h900; num_words = LEN_W'(3);
    tick();
    start = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || m_valid !== 1'b0) quiet = 1'b0;
      tick();
    end
    n_cmp++;
    if (!quiet) begin
      n_err++; $display("FAIL start_at_done: got activity after done-cycle start, required none");
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    int n;
    for (int k = 0; k < 3; k++) begin
      b = $urandom;
      n = $urandom_range(1, 12);
      run_stream("random", b, n, 2, -1);
    end
  endtask

  task automatic test_latency_rdlat2();
    int cyc;
    int first_v;
    logic [31:0] a;
    logic [W-1:0] ew;
    for (int i = 0; i < 8; i++) begin
      a = 32'h100 + 32'(i) * 32'd4;
      exp2_q.push_back({(i == 7), bram_word(a)});
    end
    base_addr_2 = 32'h100; num_words_2 = LEN_W'(8); start_2 = 1'b1;
    tick();
    start_2 = 1'b0;
    cyc = 0;
    first_v = -1;
    while (done_2 !== 1'b1 && cyc < 200) begin
      if (m_valid_2 === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        n_cmp++;
        if (exp2_q.size() == 0) begin
          n_err++; $display("FAIL lat2_spurious: got %08h, required no beat", m_data_2);
        end else begin
          ew = exp2_q.pop_front();
          if ({m_last_2, m_data_2} !== ew) begin
            n_err++;
            $display("FAIL lat2_beat: got last=%0b data=%08h, required last=%0b data=%08h",
                     m_last_2, m_data_2, ew[32], ew[31:0]);
          end
        end
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (first_v != 3) begin
      n_err++; $display("FAIL lat2_first_valid: got %0d, required 3", first_v);
    end
    n_cmp++;
    if (done_2 !== 1'b1 || exp2_q.size() != 0) begin
      n_err++; $display("FAIL lat2_complete: got done=%0b leftover=%0d, required 1 0", done_2, exp2_q.size());
    end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    run_stream("stream", 32'h100, 8, 0, 2);
    run_stream("backpressure", 32'h100, 16, 1, -1);
    test_zero_len();
    run_stream("wrap", 32'hFFFF_FFF8, 4, 0, 2);
    test_abort();
    test_start_ignored();
    test_random();
    test_latency_rdlat2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
